blit_sdram_arbiter: RTL

Shares the blitter's single SDRAM port between two requesters: the blitter read path (source/destination fetch) and the blitter write FIFO drain. It picks one requester per cycle using a run-length-limited alternating policy. An urgency override lets the write FIFO drain first when it is nearly full. It also tracks reads in flight so that read data can be routed back and its count bounded.

---
 rtl/blit_sdram_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/blit_sdram_arbiter.sv
// Arbitrates the blitter read path and write-FIFO drain onto one SDRAM port.
// Optional performance counters are enabled with the BLIT_ARB_PERF_EN macro.
module blit_sdram_arbiter #(
  parameter int unsigned MAX_RUN         = 16,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        blitr_sdram_request,
  output logic        blitr_sdram_ready,
  input  logic [25:0] blitr_sdram_address,
  output logic        blitr_sdram_rvalid,
  output logic [31:0] blitr_sdram_rdata,
  input  logic        blitw_sdram_request,
  output logic        blitw_sdram_ready,
  input  logic [25:0] blitw_sdram_address,
  input  logic [3:0]  blitw_sdram_wstrb,
  input  logic [31:0] blitw_sdram_wdata,
  input  logic        write_fifo_full,
  output logic        sdram_request,
  input  logic        sdram_ready,
  output logic        sdram_write,
  output logic [25:0] sdram_address,
  output logic [3:0]  sdram_wstrb,
  output logic [31:0] sdram_wdata,
  input  logic        sdram_rvalid,
  input  logic [31:0] sdram_rdata,
  output logic        fault_detected
`ifdef BLIT_ARB_PERF_EN
  ,
  output logic [31:0] perf_read_xfers,
  output logic [31:0] perf_write_xfers,
  output logic [31:0] perf_wait_cycles
`endif
);

  typedef enum logic {OWN_READ = 1'b0, OWN_WRITE = 1'b1} owner_t;

  localparam logic [7:0] L_MAX_RUN = 8'(MAX_RUN);
  localparam logic [3:0] L_MAX_OUT = 4'(MAX_OUTSTANDING);

  owner_t      r_owner;
  logic [7:0]  r_run_count;
  logic [3:0]  r_outstanding;
  logic        r_fault;
  logic [25:0] r_hold_address;
  logic [3:0]  r_hold_wstrb;
  logic [31:0] r_hold_wdata;

  owner_t w_sel;
  owner_t w_other;
  logic   w_sel_valid;
  logic   w_rd_ok;
  logic   w_wr_ok;
  logic   w_owner_ok;
  logic   w_other_ok;
  logic   w_run_open;
  logic   w_is_read;
  logic   w_is_write;
  logic   w_accept;
  logic   w_acc_read;

  always_comb begin
    w_rd_ok     = blitr_sdram_request && (r_outstanding < L_MAX_OUT);
    w_wr_ok     = blitw_sdram_request;
    w_other     = (r_owner == OWN_READ) ? OWN_WRITE : OWN_READ;
    w_owner_ok  = (r_owner == OWN_READ) ? w_rd_ok : w_wr_ok;
    w_other_ok  = (r_owner == OWN_READ) ? w_wr_ok : w_rd_ok;
    w_run_open  = r_run_count < L_MAX_RUN;
    w_sel       = r_owner;
    w_sel_valid = 1'b0;
    // Urgency first, then the run-limited owner, then the waiting side, then renewal.
    if (write_fifo_full && w_wr_ok) begin
      w_sel       = OWN_WRITE;
      w_sel_valid = 1'b1;
    end else if (w_owner_ok && w_run_open) begin
      w_sel       = r_owner;
      w_sel_valid = 1'b1;
    end else if (w_other_ok) begin
      w_sel       = w_other;
      w_sel_valid = 1'b1;
    end else if (w_owner_ok) begin
      w_sel       = r_owner;
      w_sel_valid = 1'b1;
    end
  end

  always_comb begin
    w_is_write = w_sel_valid && (w_sel == OWN_WRITE);
    w_is_read  = w_sel_valid && (w_sel == OWN_READ);
    w_accept   = w_sel_valid && sdram_ready;
    w_acc_read = w_accept && (w_sel == OWN_READ);

    sdram_request     = w_sel_valid;
    sdram_write       = w_is_write;
    blitr_sdram_ready = w_is_read && sdram_ready;
    blitw_sdram_ready = w_is_write && sdram_ready;

    // Idle cycles replay the last driven values rather than floating the bus.
    if (w_is_write) begin
      sdram_address = blitw_sdram_address;
      sdram_wstrb   = blitw_sdram_wstrb;
      sdram_wdata   = blitw_sdram_wdata;
    end else if (w_is_read) begin
      sdram_address = blitr_sdram_address;
      sdram_wstrb   = 4'b0000;
      sdram_wdata   = r_hold_wdata;
    end else begin
      sdram_address = r_hold_address;
      sdram_wstrb   = r_hold_wstrb;
      sdram_wdata   = r_hold_wdata;
    end

    blitr_sdram_rvalid = sdram_rvalid;
    blitr_sdram_rdata  = sdram_rdata;
    fault_detected     = r_fault;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_owner        <= OWN_READ;
      r_run_count    <= '0;
      r_outstanding  <= '0;
      r_fault        <= 1'b0;
      r_hold_address <= '0;
      r_hold_wstrb   <= '0;
      r_hold_wdata   <= '0;
    end else begin
      if (w_sel_valid) begin
        r_hold_address <= sdram_address;
        r_hold_wstrb   <= sdram_wstrb;
        r_hold_wdata   <= sdram_wdata;
      end

      if (w_accept) begin
        if ((w_sel == r_owner) && w_run_open) begin
          r_run_count <= r_run_count + 8'd1;
        end else begin
          r_owner     <= w_sel;
          r_run_count <= 8'd1;
        end
      end

      r_fault <= (sdram_rvalid && (r_outstanding == '0)) ||
                 (w_acc_read && (r_outstanding == L_MAX_OUT));

      case ({w_acc_read, sdram_rvalid})
        2'b10: if (r_outstanding != '1) r_outstanding <= r_outstanding + 4'd1;
        2'b01: if (r_outstanding != '0) r_outstanding <= r_outstanding - 4'd1;
        default: ;
      endcase
    end
  end

`ifdef BLIT_ARB_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_read_xfers  <= '0;
      perf_write_xfers <= '0;
      perf_wait_cycles <= '0;
    end else begin
      if (w_acc_read)                perf_read_xfers  <= perf_read_xfers + 32'd1;
      if (w_accept && w_is_write)    perf_write_xfers <= perf_write_xfers + 32'd1;
      if (w_sel_valid && !sdram_ready) perf_wait_cycles <= perf_wait_cycles + 32'd1;
    end
  end
`else
  // No performance counters in this build.
`endif

endmodule
